uart_tx: RTL and testbench

UART transmit engine that serializes bytes onto the Tx_out line. It is the counterpart of the existing receiver that reads Rx_in and flags frame/parity/overrun errors. Frame format is 8N1, 8E1 or 8O1, with an optional second stop bit, at a fixed baud derived from the 50 MHz system clock. A one-entry holding register in front of the shift register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_if.sv | 29 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Frame-format encodings and baud arithmetic shared by TX and RX.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic c_PARITY_EVEN = 1'b0;
  localparam logic c_PARITY_ODD  = 1'b1;

  // Truncating division: the small rate error is accepted by both ends.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_if
// Purpose  : Byte handshake and frame-format controls into the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              parity_en;
  logic              parity_odd;
  logic              two_stop;

  modport master (
    output tx_data, tx_valid, parity_en, parity_odd, two_stop,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, parity_en, parity_odd, two_stop,
    output tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-time counter; bit_done marks the last cycle of each bit time.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_done = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1/8E1/8O1 (+optional 2nd stop) serializer with a one-byte holding
//            register for gapless back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DATA_W   = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_if.slave    bus,
  output logic     Tx_out,
  output logic     busy
);

  localparam int                 c_CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int                 c_IDX_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST     = c_IDX_W'(DATA_W - 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_hold_full;
  logic                r_par_en;
  logic                r_two_stop;
  logic                r_parity;
  logic                r_stop_second;
  logic [c_IDX_W-1:0]  r_bit_idx;

  logic                w_bit_done;
  logic                w_accept;
  logic                w_end_frame;
  logic                w_load;
  logic [DATA_W-1:0]   w_load_data;

  assign bus.tx_ready = !r_hold_full;
  assign w_accept     = bus.tx_valid && !r_hold_full;
  assign w_end_frame  = (r_state == ST_STOP) && w_bit_done && (!r_two_stop || r_stop_second);
  // The shifter is (re)loaded either from the idle line or at the final stop cycle.
  assign w_load       = ((r_state == ST_IDLE) && (w_accept || r_hold_full)) ||
                        (w_end_frame && r_hold_full);
  assign w_load_data  = r_hold_full ? r_hold_data : bus.tx_data;

  uart_baud_gen #(
    .CLKS_PER_BIT (c_CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_load),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_hold_data   <= '0;
      r_hold_full   <= 1'b0;
      r_par_en      <= 1'b0;
      r_two_stop    <= 1'b0;
      r_parity      <= 1'b0;
      r_stop_second <= 1'b0;
      r_bit_idx     <= '0;
      Tx_out        <= 1'b1;
      busy          <= 1'b0;
    end else begin
      if (w_accept && (r_state != ST_IDLE)) begin
        r_hold_data <= bus.tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_state       <= ST_START;
        r_shift       <= w_load_data;
        r_parity      <= (^w_load_data) ^ (bus.parity_odd == c_PARITY_ODD);
        r_par_en      <= bus.parity_en;
        r_two_stop    <= bus.two_stop;
        r_stop_second <= 1'b0;
        r_bit_idx     <= '0;
        Tx_out        <= 1'b0;
        busy          <= 1'b1;
      end else if (w_bit_done) begin
        case (r_state)
          ST_START: begin
            r_state <= ST_DATA;
            Tx_out  <= r_shift[0];
          end
          ST_DATA: begin
            if (r_bit_idx == c_IDX_LAST) begin
              if (r_par_en) begin
                r_state <= ST_PARITY;
                Tx_out  <= r_parity;
              end else begin
                r_state <= ST_STOP;
                Tx_out  <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              Tx_out    <= r_shift[1];
            end
          end
          ST_PARITY: begin
            r_state <= ST_STOP;
            Tx_out  <= 1'b1;
          end
          ST_STOP: begin
            if (r_two_stop && !r_stop_second) begin
              r_stop_second <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx against a bit-list frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int c_CLKS = 50_000_000 / 115200;

  logic clk;
  logic rst;
  logic Tx_out;
  logic busy;

  uart_if #(.DATA_W(8)) bus ();

  uart_tx #(
    .CLK_FREQ (50_000_000),
    .BAUD     (115200),
    .DATA_W   (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .Tx_out (Tx_out),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drop    = 1'b0;

  // Expected line, one entry per bit time, plus timed side events.
  logic       exp_q[$];
  int         q_inj_cyc[$];
  logic [7:0] q_inj_dat[$];
  int         q_rdy_cyc[$];
  logic       q_rdy_val[$];
  int         q_cfg_cyc[$];
  logic [2:0] q_cfg_val[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input logic pen, input logic podd,
                           input logic two);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back((^d) ^ podd);
    exp_q.push_back(1'b1);
    if (two) exp_q.push_back(1'b1);
  endtask

  task automatic set_cfg(input logic pen, input logic podd, input logic two);
    bus.parity_en  = pen;
    bus.parity_odd = podd;
    bus.two_stop   = two;
  endtask

  task automatic kick(input string tag, input logic [7:0] d);
    @(negedge clk);
    chk1({tag, "_ready_before"}, bus.tx_ready, 1'b1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    drop         = 1'b1;
  endtask

  // Cycle 0 is the first cycle after the accepting edge.
  task automatic run_stream(input string tag);
    int cyc;
    int bitn;
    cyc  = 0;
    bitn = 0;
    while (exp_q.size() > 0) begin
      logic lvl;
      int   bad;
      int   bbad;
      lvl  = exp_q.pop_front();
      bad  = 0;
      bbad = 0;
      repeat (c_CLKS) begin
        @(negedge clk);
        if (drop) begin
          bus.tx_valid = 1'b0;
          drop         = 1'b0;
        end
        if (Tx_out !== lvl) bad++;
        if (busy !== 1'b1) bbad++;
        while (q_rdy_cyc.size() > 0 && q_rdy_cyc[0] == cyc) begin
          void'(q_rdy_cyc.pop_front());
          chk1($sformatf("%s_ready@%0d", tag, cyc), bus.tx_ready, q_rdy_val.pop_front());
        end
        if (q_inj_cyc.size() > 0 && q_inj_cyc[0] == cyc) begin
          void'(q_inj_cyc.pop_front());
          bus.tx_data  = q_inj_dat.pop_front();
          bus.tx_valid = 1'b1;
          drop         = 1'b1;
        end
        if (q_cfg_cyc.size() > 0 && q_cfg_cyc[0] == cyc) begin
          void'(q_cfg_cyc.pop_front());
          {bus.parity_en, bus.parity_odd, bus.two_stop} = q_cfg_val.pop_front();
        end
        cyc++;
      end
      chkn($sformatf("%s_bit%0d_level_errs(exp %b)", tag, bitn, lvl), bad, 0);
      chkn($sformatf("%s_bit%0d_busy_errs", tag, bitn), bbad, 0);
      bitn++;
    end
    @(negedge clk);
    chk1({tag, "_idle_line"}, Tx_out, 1'b1);
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk1({tag, "_idle_ready"}, bus.tx_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] cfg;
    int         len;
    int         inj;

    rst          = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk1("reset_line", Tx_out, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_ready", bus.tx_ready, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0x55: alternating line, 10 bit times
    set_cfg(1'b0, 1'b0, 1'b0);
    kick("n1_55", 8'h55);
    add_frame(8'h55, 1'b0, 1'b0, 1'b0);
    q_rdy_cyc.push_back(0); q_rdy_val.push_back(1'b1);
    run_stream("n1_55");

    // 8E1 / 8O1 'N'
    set_cfg(1'b1, 1'b0, 1'b0);
    kick("e1_4e", 8'h4E);
    add_frame(8'h4E, 1'b1, 1'b0, 1'b0);
    run_stream("e1_4e");

    set_cfg(1'b1, 1'b1, 1'b0);
    kick("o1_4e", 8'h4E);
    add_frame(8'h4E, 1'b1, 1'b1, 1'b0);
    run_stream("o1_4e");

    // Back-to-back 'N','I'; extra offers while full and on the transfer cycle are refused
    set_cfg(1'b1, 1'b0, 1'b0);
    len = c_CLKS * 11;
    kick("b2b", 8'h4E);
    add_frame(8'h4E, 1'b1, 1'b0, 1'b0);
    add_frame(8'h49, 1'b1, 1'b0, 1'b0);
    q_inj_cyc.push_back(1000);    q_inj_dat.push_back(8'h49);
    q_inj_cyc.push_back(2000);    q_inj_dat.push_back(8'hA5);
    q_inj_cyc.push_back(len - 1); q_inj_dat.push_back(8'h3C);
    q_rdy_cyc.push_back(999);     q_rdy_val.push_back(1'b1);
    q_rdy_cyc.push_back(1001);    q_rdy_val.push_back(1'b0);
    q_rdy_cyc.push_back(len - 1); q_rdy_val.push_back(1'b0);
    q_rdy_cyc.push_back(len);     q_rdy_val.push_back(1'b1);
    run_stream("b2b");

    // 8N2 0xFF
    set_cfg(1'b0, 1'b0, 1'b1);
    kick("n2_ff", 8'hFF);
    add_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    run_stream("n2_ff");

    // two_stop and parity controls changed mid-frame must not alter the frame
    set_cfg(1'b0, 1'b0, 1'b1);
    kick("n2_toggle", 8'hA3);
    add_frame(8'hA3, 1'b0, 1'b0, 1'b1);
    q_cfg_cyc.push_back(c_CLKS * 4); q_cfg_val.push_back(3'b110);
    run_stream("n2_toggle");

    // Asynchronous reset during DATA of 0x00
    set_cfg(1'b0, 1'b0, 1'b0);
    kick("rst_mid", 8'h00);
    repeat (c_CLKS * 3 + 200) begin
      @(negedge clk);
      if (drop) begin
        bus.tx_valid = 1'b0;
        drop         = 1'b0;
      end
    end
    chk1("rst_mid_pre_line", Tx_out, 1'b0);
    chk1("rst_mid_pre_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("rst_mid_line", Tx_out, 1'b1);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_ready", bus.tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    set_cfg(1'b1, 1'b1, 1'b0);
    kick("rst_after", 8'hC6);
    add_frame(8'hC6, 1'b1, 1'b1, 1'b0);
    run_stream("rst_after");

    // Randomized single frames with random mid-frame control changes
    for (int r = 0; r < 3; r++) begin
      d1  = 8'($urandom);
      cfg = 3'($urandom);
      set_cfg(cfg[2], cfg[1], cfg[0]);
      len = c_CLKS * (10 + int'(cfg[2]) + int'(cfg[0]));
      kick($sformatf("rnd%0d", r), d1);
      add_frame(d1, cfg[2], cfg[1], cfg[0]);
      q_cfg_cyc.push_back(int'($urandom_range(len - 1, 1)));
      q_cfg_val.push_back(3'($urandom));
      run_stream($sformatf("rnd%0d", r));
    end

    // Randomized back-to-back pair
    d1  = 8'($urandom);
    d2  = 8'($urandom);
    cfg = 3'($urandom);
    set_cfg(cfg[2], cfg[1], cfg[0]);
    len = c_CLKS * (10 + int'(cfg[2]) + int'(cfg[0]));
    inj = int'($urandom_range(len - 2, 1));
    kick("rnd_b2b", d1);
    add_frame(d1, cfg[2], cfg[1], cfg[0]);
    add_frame(d2, cfg[2], cfg[1], cfg[0]);
    q_inj_cyc.push_back(inj);     q_inj_dat.push_back(d2);
    q_rdy_cyc.push_back(inj + 1); q_rdy_val.push_back(1'b0);
    q_rdy_cyc.push_back(len - 1); q_rdy_val.push_back(1'b0);
    q_rdy_cyc.push_back(len);     q_rdy_val.push_back(1'b1);
    run_stream("rnd_b2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
